imm_ext_arbiter: RTL and testbench
==================================

# imm_ext_arbiter

Shares one immediate-extension unit between two datapath requesters: port A (I-type ALU immediates) and port B (branch/jump offsets). Each port hands over a 16-bit immediate plus a mode through a valid/ready handshake. A round-robin arbiter grants one request per cycle, extends the immediate to 32 bits, and holds the result in a single registered output slot with its own valid/ready handshake. The block sits between decode and the execute-stage operand mux.

## Interface
- TAG_W, 3, width of the opaque tag carried from request to result
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  port A request valid
- a_ready  out  1  port A request accepted this cycle
- a_imm  in  16  port A immediate
- a_mode  in  2  port A extension mode
- a_tag  in  TAG_W  port A tag
- b_valid, b_ready, b_imm, b_mode, b_tag: same widths and meanings as port A, for port B
- out_valid  out  1  result slot holds valid data
- out_ready  in  1  consumer takes the result this cycle
- out_data  out  32  extended immediate
- out_src  out  1  granted port: 0 = A, 1 = B
- out_tag  out  TAG_W  tag of the granted request

## Operation
- Modes:
  - 00 SEXT: {16{imm[15]}, imm}
  - 01 ZEXT: {16'b0, imm}
  - 10 LUI: {imm, 16'b0}
  - 11 BRSH: sign-extend, then shift left 2. Bits shifted out of bit 31 are dropped, result bits [1:0] = 0.
- Slot FSM, 2 states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- can_accept = EMPTY, or (FULL and out_ready).
- Arbitration:
  - If only one port is valid and can_accept = 1, that port is granted.
  - If both ports are valid, the port not granted last is granted.
  - last_grant updates only on an actual grant.
- x_ready = can_accept and (grant == x). Ready is combinational from valid, the slot state and out_ready. No combinational path from any data input to any ready.
- A transfer happens when x_valid and x_ready are both 1.
  - On transfer, the slot loads the extended data, src and tag, and the FSM goes to or stays in FULL.
- If the slot drains (out_valid and out_ready) with no grant in that cycle, the FSM goes to EMPTY.
- A drain and a new grant in the same cycle keep the FSM in FULL with the new data (back-to-back throughput of 1 per cycle).
- Requesters hold valid, imm, mode and tag stable until ready is seen. The arbiter does not re-arbitrate away from a pending request it has already granted: the grant is evaluated only in cycles where can_accept = 1.
- Out-of-range behaviour: none. All 2-bit modes are defined.

## Timing
- Latency: a request accepted at edge N appears on out_* after edge N, i.e. valid in cycle N+1.
- Throughput: 1 result per cycle while out_ready = 1. Each port gets at most every other slot while both ports are valid.
- Backpressure: with out_ready = 0 in FULL, both readies are 0 and out_* is held bit-stable.
- Reset values (asynchronous, while rst_n = 0):
  - out_valid = 0, out_data = 0, out_src = 0, out_tag = 0
  - FSM = EMPTY
  - last_grant = B, so A wins the first contention
- Reset mid-operation: any result in the slot is discarded and no request is accepted during reset. After deassertion, the first edge can accept.
- Readies are 0 while rst_n = 0.

## Structure
- Package imm_ext_pkg:
  - mode typedef/constants: MODE_SEXT = 2'b00, MODE_ZEXT = 2'b01, MODE_LUI = 2'b10, MODE_BRSH = 2'b11
  - slot state constants: ST_EMPTY, ST_FULL
  - source constants: SRC_A = 0, SRC_B = 1
- Sub-module imm_ext_core: purely combinational, (imm[15:0], mode[1:0]) -> data[31:0]. One instance sits after the arbiter mux.
- Top level contains the arbiter, the last_grant register, the FSM and the output slot registers.

## Test plan
- Reset, then A SEXT imm = 16'd3782 with out_ready = 1 -> next cycle out_data = 32'h00000EC6, out_src = 0, tag echoed.
- A SEXT imm = 16'hFFD5 (−43) -> out_data = 32'hFFFFFFD5. Same imm with ZEXT -> 32'h0000FFD5.
- B LUI imm = 16'h1234 -> 32'h12340000. B BRSH imm = 16'hFFFF -> 32'hFFFFFFFC. B BRSH imm = 16'h4001 -> 32'h00010004.
- A and B both valid continuously with out_ready = 1 -> out_src sequence 0,1,0,1. One result per cycle, no loss, tags match.
- Slot FULL, out_ready = 0 for 3 cycles with both ports valid -> a_ready = b_ready = 0 and out_* stable. Raising out_ready drains the slot and accepts the next request in the same cycle.
- rst_n pulsed low while FULL with requests pending -> out_valid = 0 immediately (asynchronous). After release, A is granted first.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension arbiter: extension modes,
// output-slot states and requester identifiers.
package imm_ext_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SEXT = 2'b00;
    localparam mode_t MODE_ZEXT = 2'b01;
    localparam mode_t MODE_LUI  = 2'b10;
    localparam mode_t MODE_BRSH = 2'b11;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: 16-bit immediate plus mode -> 32-bit operand.
module imm_ext_core
    import imm_ext_pkg::*;
(
    input  logic [15:0] imm,
    input  logic [1:0]  mode,
    output logic [31:0] data
);

    logic [31:0] sext;

    assign sext = {{16{imm[15]}}, imm};

    // Select the extension form; branch offsets are word-scaled sign extensions.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        data = sext;
        case (mode)
            MODE_SEXT: data = sext;
            MODE_ZEXT: data = {16'h0000, imm};
            MODE_LUI:  data = {imm, 16'h0000};
            MODE_BRSH: data = {sext[29:0], 2'b00};
            default:   data = sext;
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Two-port round-robin arbiter in front of one shared immediate extender,
// with a single registered result slot and valid/ready handshakes on all sides.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [15:0]      a_imm,
    input  logic [1:0]       a_mode,
    input  logic [TAG_W-1:0] a_tag,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic [15:0]      b_imm,
    input  logic [1:0]       b_mode,
    input  logic [TAG_W-1:0] b_tag,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag
);

    logic             state;
    logic             last_grant;
    logic             can_accept;
    logic             grant_src;
    logic             grant_fire;
    logic [15:0]      sel_imm;
    logic [1:0]       sel_mode;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      ext_data;

    // The slot can take a new result when empty or when it is being drained this cycle;
    // rst_n gates it so nothing is accepted while reset is held.
    assign can_accept = rst_n & ((state == ST_EMPTY) | out_ready);

    // Round-robin choice; depends only on valids and last_grant, never on data inputs.
    always_comb begin
        grant_src = SRC_A;
        if (a_valid && b_valid) begin
            grant_src = (last_grant == SRC_B) ? SRC_A : SRC_B;
        end else if (b_valid) begin
            grant_src = SRC_B;
        end
    end

    assign a_ready    = can_accept & a_valid & (grant_src == SRC_A);
    assign b_ready    = can_accept & b_valid & (grant_src == SRC_B);
    assign grant_fire = a_ready | b_ready;

    // Steer the granted request into the single shared extender.
    always_comb begin
        sel_imm  = a_imm;
        sel_mode = a_mode;
        sel_tag  = a_tag;
        if (grant_src == SRC_B) begin
            sel_imm  = b_imm;
            sel_mode = b_mode;
            sel_tag  = b_tag;
        end
    end

    imm_ext_core u_core (
        .imm  (sel_imm),
        .mode (sel_mode),
        .data (ext_data)
    );

    // Slot occupancy: fill on any grant, empty on a drain with no refill.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else if (grant_fire) begin
            state <= ST_FULL;
        end else if (state == ST_FULL && out_ready) begin
            state <= ST_EMPTY;
        end
    end

    // Remember the winner of the last real grant; B after reset so A wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_B;
        end else if (grant_fire) begin
            last_grant <= grant_src;
        end
    end

    // Result slot registers, loaded only on a transfer so backpressure holds them bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload is reset too because consumers may observe out_data/out_tag while out_valid is low.
        if (!rst_n) begin
            out_data <= 32'h0000_0000;
            out_src  <= SRC_A;
            out_tag  <= '0;
        end else if (grant_fire) begin
            out_data <= ext_data;
            out_src  <= grant_src;
            out_tag  <= sel_tag;
        end
    end

    assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_imm_ext_arbiter;

    localparam int TAG_W = 3;

    logic             clk;
    logic             rst_n;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready;
    logic [15:0]      a_imm, b_imm;
    logic [1:0]       a_mode, b_mode;
    logic [TAG_W-1:0] a_tag, b_tag;
    logic             out_valid, out_ready, out_src;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_errors = 0;

    imm_ext_arbiter #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_imm     (a_imm),
        .a_mode    (a_mode),
        .a_tag     (a_tag),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_imm     (b_imm),
        .b_mode    (b_mode),
        .b_tag     (b_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_tag   (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        port;
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [2:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural extension: plain integer arithmetic, wrapped to 32 bits.
    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] mode);
        int          s;
        logic [31:0] u;
        s = int'($signed(imm));
        u = {16'h0000, imm};
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return u;
            2'd2:    return u * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
    endtask

    // One isolated request on a single port, slot drained every cycle.
    task automatic send_one(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        out_ready = 1'b1;
        if (v.port == 1'b0) begin
            a_valid = 1'b1; a_imm = v.imm; a_mode = v.mode; a_tag = v.tag;
        end else begin
            b_valid = 1'b1; b_imm = v.imm; b_mode = v.mode; b_tag = v.tag;
        end
        #1;
        check({nm, "_a_ready"}, 32'(a_ready), 32'(v.port == 1'b0));
        check({nm, "_b_ready"}, 32'(b_ready), 32'(v.port == 1'b1));
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check({nm, "_out_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_out_data"},  out_data, v.exp);
        check({nm, "_out_src"},   32'(out_src), 32'(v.port));
        check({nm, "_out_tag"},   32'(out_tag), 32'(v.tag));
    endtask

    initial begin
        logic [31:0] exp_data;
        logic [2:0]  exp_tag;
        logic        exp_src;
        logic [2:0]  ta, tb;
        // random-phase model state
        logic        m_full, m_src, m_last_b, can, win_a, win_b;
        logic [31:0] m_data;
        logic [2:0]  m_tag;
        logic        pa, pb;

        vecs[0] = '{1'b0, 16'd3782,  2'b00, 3'd5, 32'h0000_0EC6};
        vecs[1] = '{1'b0, 16'hFFD5,  2'b00, 3'd1, 32'hFFFF_FFD5};
        vecs[2] = '{1'b0, 16'hFFD5,  2'b01, 3'd2, 32'h0000_FFD5};
        vecs[3] = '{1'b1, 16'h1234,  2'b10, 3'd3, 32'h1234_0000};
        vecs[4] = '{1'b1, 16'hFFFF,  2'b11, 3'd4, 32'hFFFF_FFFC};
        vecs[5] = '{1'b1, 16'h4001,  2'b11, 3'd6, 32'h0001_0004};
        vecs[6] = '{1'b0, 16'h8000,  2'b11, 3'd7, 32'hFFFE_0000};
        vecs[7] = '{1'b1, 16'h8000,  2'b01, 3'd0, 32'h0000_8000};
        vecs[8] = '{1'b0, 16'hFFFF,  2'b10, 3'd2, 32'hFFFF_0000};
        vecs[9] = '{1'b1, 16'h7FFF,  2'b00, 3'd5, 32'h0000_7FFF};

        // Reset state, with a request already presented.
        rst_n = 1'b0; out_ready = 1'b1;
        a_valid = 1'b1; a_imm = 16'h1111; a_mode = 2'b00; a_tag = 3'd1;
        b_valid = 1'b1; b_imm = 16'h2222; b_mode = 2'b00; b_tag = 3'd2;
        #2;
        check("rst_a_ready",   32'(a_ready), 32'd0);
        check("rst_b_ready",   32'(b_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_src",   32'(out_src), 32'd0);
        check("rst_out_tag",   32'(out_tag), 32'd0);
        tick();
        tick();
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;

        // Directed single-request vectors.
        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i], i);
        end
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Both ports valid continuously: strict alternation starting with A.
        pulse_reset();
        out_ready = 1'b1;
        ta = 3'd0; tb = 3'd4;
        a_valid = 1'b1; a_imm = 16'h8001; a_mode = 2'b00; a_tag = ta;
        b_valid = 1'b1; b_imm = 16'h2001; b_mode = 2'b10; b_tag = tb;
        exp_data = '0; exp_tag = '0; exp_src = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("alt%0d_a_ready", i), 32'(a_ready), 32'(i % 2 == 0));
            check($sformatf("alt%0d_b_ready", i), 32'(b_ready), 32'(i % 2 == 1));
            exp_src  = (i % 2 == 1);
            exp_data = exp_src ? ext_model(b_imm, b_mode) : ext_model(a_imm, a_mode);
            exp_tag  = exp_src ? b_tag : a_tag;
            tick();
            check($sformatf("alt%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("alt%0d_out_src", i),   32'(out_src), 32'(exp_src));
            check($sformatf("alt%0d_out_tag", i),   32'(out_tag), 32'(exp_tag));
            check($sformatf("alt%0d_out_data", i),  out_data, exp_data);
            if (exp_src) begin
                tb = tb + 3'd1; b_tag = tb; b_imm = b_imm + 16'd1;
            end else begin
                ta = ta + 3'd1; a_tag = ta; a_imm = a_imm + 16'd1;
            end
        end

        // Backpressure: slot full with B result, both ports pending.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_a_ready", i), 32'(a_ready), 32'd0);
            check($sformatf("bp%0d_b_ready", i), 32'(b_ready), 32'd0);
            tick();
            check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_out_data", i),  out_data, exp_data);
            check($sformatf("bp%0d_out_src", i),   32'(out_src), 32'd1);
            check($sformatf("bp%0d_out_tag", i),   32'(out_tag), 32'(exp_tag));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_a_ready", 32'(a_ready), 32'd1);
        check("bp_release_b_ready", 32'(b_ready), 32'd0);
        tick();
        check("bp_release_out_valid", 32'(out_valid), 32'd1);
        check("bp_release_out_src",   32'(out_src), 32'd0);
        check("bp_release_out_tag",   32'(out_tag), 32'(a_tag));
        check("bp_release_out_data",  out_data, ext_model(a_imm, a_mode));

        // Asynchronous reset while FULL with requests pending.
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  out_data, 32'd0);
        check("mid_rst_a_ready",   32'(a_ready), 32'd0);
        check("mid_rst_b_ready",   32'(b_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_ready), 32'd0);
        tick();
        check("post_rst_out_src", 32'(out_src), 32'd0);
        check("post_rst_out_tag", 32'(out_tag), 32'(a_tag));

        // Randomized traffic against the behavioural model.
        pulse_reset();
        m_full = 1'b0; m_data = '0; m_src = 1'b0; m_tag = '0; m_last_b = 1'b1;
        pa = 1'b0; pb = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pa && $urandom_range(0, 1) == 1) begin
                pa = 1'b1;
                a_imm = 16'($urandom); a_mode = 2'($urandom_range(0, 3)); a_tag = 3'($urandom_range(0, 7));
            end
            if (!pb && $urandom_range(0, 1) == 1) begin
                pb = 1'b1;
                b_imm = 16'($urandom); b_mode = 2'($urandom_range(0, 3)); b_tag = 3'($urandom_range(0, 7));
            end
            a_valid = pa;
            b_valid = pb;
            #1;
            can   = !m_full || out_ready;
            win_a = can && pa && (!pb || m_last_b);
            win_b = can && pb && (!pa || !m_last_b);
            check("rnd_a_ready", 32'(a_ready), 32'(win_a));
            check("rnd_b_ready", 32'(b_ready), 32'(win_b));
            tick();
            if (win_a) begin
                m_full = 1'b1; m_data = ext_model(a_imm, a_mode); m_src = 1'b0; m_tag = a_tag;
                m_last_b = 1'b0; pa = 1'b0;
            end else if (win_b) begin
                m_full = 1'b1; m_data = ext_model(b_imm, b_mode); m_src = 1'b1; m_tag = b_tag;
                m_last_b = 1'b1; pb = 1'b0;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
            check("rnd_out_valid", 32'(out_valid), 32'(m_full));
            if (m_full) begin
                check("rnd_out_data", out_data, m_data);
                check("rnd_out_src",  32'(out_src), 32'(m_src));
                check("rnd_out_tag",  32'(out_tag), 32'(m_tag));
            end
        end

        a_valid = 1'b0;
        b_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
